// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO pop interface to first-word-fall-through valid/ready stream
// Two-entry registered skid buffer; supports memory read latency 0 or 1.
module fifo_rd_stream #(
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rden,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        level
);

  generate
    if (RD_LAT != 0 && RD_LAT != 1) begin : g_bad_rd_lat
      $error("fifo_rd_stream: RD_LAT must be 0 or 1");
    end
  endgenerate

  logic [1:0]        held;
  logic              inflight;
  logic              pop;
  logic              cap;
  logic [2:0]        used_after;
  logic [DWIDTH-1:0] head;
  logic [DWIDTH-1:0] tail;

  assign pop        = m_valid & m_ready;
  assign used_after = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
  // m_ready reaches fifo_rden combinationally so a full buffer can refill while draining
  assign fifo_rden  = rstn & ~fifo_empty & ~flush & (used_after < 3'd2);

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inflight <= 1'b0;
        else       inflight <= fifo_rden;
      end
      // a word returning on the flush edge is dropped
      assign cap = inflight & ~flush;
    end else begin : g_lat0
      assign inflight = 1'b0;
      assign cap      = fifo_rden;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      held <= 2'd0;
    end else if (pop && held == 2'd2) begin
      head <= tail;
      if (cap) tail <= fifo_dout;
      else     held <= 2'd1;
    end else if (pop) begin
      if (cap) head <= fifo_dout;
      else     held <= 2'd0;
    end else if (cap) begin
      if (held == 2'd0) begin
        head <= fifo_dout;
        held <= 2'd1;
      end else begin
        tail <= fifo_dout;
        held <= 2'd2;
      end
    end
  end

  always @(posedge clk) begin
    if (rstn && cap && !pop) assert (held != 2'd2);
  end

  assign m_valid = (held != 2'd0);
  assign m_data  = head;
  assign level   = held;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed table-driven bench for fifo_rd_stream
// Two DUTs (RD_LAT 0 and 1), each fed by its own small FIFO model.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       m_ready = 1'b0;

  logic       e0, e1, rd0, rd1, v0, v1;
  logic [7:0] d0, d1, dat0, dat1;
  logic [1:0] lv0, lv1;

  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  logic [7:0] dq1;
  int         wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign e0 = (wp0 == rp0);
  assign e1 = (wp1 == rp1);
  assign d0 = mem0[rp0[5:0]];
  assign d1 = dq1;

  always @(posedge clk) if (rd0) rp0 <= rp0 + 1;
  always @(posedge clk) begin
    if (rd1) begin
      rp1 <= rp1 + 1;
      dq1 <= mem1[rp1[5:0]];
    end
  end

  fifo_rd_stream #(.DWIDTH(8), .RD_LAT(0)) u_lat0 (
    .clk(clk), .rstn(rstn), .fifo_empty(e0), .fifo_dout(d0), .fifo_rden(rd0),
    .flush(flush), .m_valid(v0), .m_ready(m_ready), .m_data(dat0), .level(lv0)
  );

  fifo_rd_stream #(.DWIDTH(8), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .fifo_empty(e1), .fifo_dout(d1), .fifo_rden(rd1),
    .flush(flush), .m_valid(v1), .m_ready(m_ready), .m_data(dat1), .level(lv1)
  );

  typedef struct {
    logic       lat;
    logic       rdy;
    logic       fl;
    logic       exp_rden;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_level;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input logic lat, input logic rdy, input logic fl, input logic rd,
                     input logic v, input logic [7:0] d, input logic [1:0] l);
    tbl.push_back('{lat, rdy, fl, rd, v, d, l});
  endtask

  task automatic push(input logic lat, input logic [7:0] val);
    if (lat == 1'b0) begin
      mem0[wp0[5:0]] = val;
      wp0++;
    end else begin
      mem1[wp1[5:0]] = val;
      wp1++;
    end
  endtask

  task automatic run_tbl(input string tname);
    logic       ar, av;
    logic [7:0] ad;
    logic [1:0] al;
    for (int i = 0; i < tbl.size(); i++) begin
      m_ready = tbl[i].rdy;
      flush   = tbl[i].fl;
      #1;
      if (tbl[i].lat == 1'b0) begin ar = rd0; av = v0; ad = dat0; al = lv0; end
      else                    begin ar = rd1; av = v1; ad = dat1; al = lv1; end
      chk($sformatf("%s[%0d].rden", tname, i), {7'd0, ar}, {7'd0, tbl[i].exp_rden});
      chk($sformatf("%s[%0d].valid", tname, i), {7'd0, av}, {7'd0, tbl[i].exp_valid});
      chk($sformatf("%s[%0d].level", tname, i), {6'd0, al}, {6'd0, tbl[i].exp_level});
      if (tbl[i].exp_valid)
        chk($sformatf("%s[%0d].data", tname, i), ad, tbl[i].exp_data);
      @(negedge clk);
    end
    tbl.delete();
    flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.valid0", {7'd0, v0}, 8'd0);
    chk("reset.valid1", {7'd0, v1}, 8'd0);
    chk("reset.level0", {6'd0, lv0}, 8'd0);
    chk("reset.data1", dat1, 8'd0);
    rstn = 1'b1;
    @(negedge clk);

    // latency 0, three words streaming
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    row(0,1,0, 1,0,8'h00,0);
    row(0,1,0, 1,1,8'h11,1);
    row(0,1,0, 1,1,8'h22,1);
    row(0,1,0, 0,1,8'h33,1);
    row(0,1,0, 0,0,8'h00,0);
    run_tbl("lat0_stream");

    // latency 1, eight back-to-back beats
    for (int k = 0; k < 8; k++) push(1, 8'(k));
    row(1,1,0, 1,0,8'h00,0);
    row(1,1,0, 1,0,8'h00,0);
    for (int k = 0; k < 8; k++) row(1,1,0, (k <= 5), 1, 8'(k), 1);
    row(1,1,0, 0,0,8'h00,0);
    run_tbl("lat1_stream");

    // latency 1 backpressure then release
    for (int k = 0; k < 4; k++) push(1, 8'(k));
    row(1,0,0, 1,0,8'h00,0);
    row(1,0,0, 1,0,8'h00,0);
    row(1,0,0, 0,1,8'h00,1);
    row(1,0,0, 0,1,8'h00,2);
    row(1,0,0, 0,1,8'h00,2);
    row(1,1,0, 1,1,8'h00,2);
    row(1,1,0, 1,1,8'h01,1);
    row(1,1,0, 0,1,8'h02,1);
    row(1,1,0, 0,1,8'h03,1);
    row(1,1,0, 0,0,8'h00,0);
    run_tbl("lat1_bp");

    // latency 0, pop and refill with buffer full
    push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    row(0,0,0, 1,0,8'h00,0);
    row(0,0,0, 1,1,8'hA0,1);
    row(0,0,0, 0,1,8'hA0,2);
    row(0,1,0, 1,1,8'hA0,2);
    row(0,1,0, 1,1,8'hA1,2);
    row(0,1,0, 0,1,8'hA2,2);
    row(0,1,0, 0,1,8'hA3,1);
    row(0,1,0, 0,0,8'h00,0);
    run_tbl("lat0_full");

    // latency 1 flush with a word in flight; B2 must never appear
    push(1, 8'hB0); push(1, 8'hB1); push(1, 8'hB2); push(1, 8'hB3);
    row(1,0,0, 1,0,8'h00,0);
    row(1,0,0, 1,0,8'h00,0);
    row(1,0,0, 0,1,8'hB0,1);
    row(1,0,0, 0,1,8'hB0,2);
    row(1,1,0, 1,1,8'hB0,2);
    row(1,1,1, 0,1,8'hB1,1);
    row(1,1,0, 1,0,8'h00,0);
    row(1,1,0, 0,0,8'h00,0);
    row(1,1,0, 0,1,8'hB3,1);
    row(1,1,0, 0,0,8'h00,0);
    run_tbl("lat1_flush");

    // asynchronous reset with the buffer full
    push(0, 8'hC0); push(0, 8'hC1); push(0, 8'hC2);
    row(0,0,0, 1,0,8'h00,0);
    row(0,0,0, 1,1,8'hC0,1);
    row(0,0,0, 0,1,8'hC0,2);
    run_tbl("pre_reset");
    rstn = 1'b0;
    #1;
    chk("async_rst.valid", {7'd0, v0}, 8'd0);
    chk("async_rst.level", {6'd0, lv0}, 8'd0);
    chk("async_rst.rden", {7'd0, rd0}, 8'd0);
    chk("async_rst.data", dat0, 8'd0);
    wp0 = rp0;
    @(negedge clk);
    rstn = 1'b1;
    push(0, 8'hD5);
    row(0,1,0, 1,0,8'h00,0);
    row(0,1,0, 0,1,8'hD5,1);
    row(0,1,0, 0,0,8'h00,0);
    run_tbl("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
